if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage RV64 pipeline; producer side of the fs->ds interface.
//  Holds the fetch PC and issues requests on a req/addr_ok/data_ok instruction-SRAM port.
//  Delivers {inst, pc} to decode over the valid/allowin handshake and takes redirects from decode's br_bus.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000   PC of the first fetch after reset release
// PORTS
//  clk                input   1    single clock, all state on posedge
//  reset              input   1    asynchronous, active-low (asserted when 0)
//  ds_allowin         input   1    decode can accept a bundle this cycle
//  br_bus             input   65   {br_taken[64], br_target[63:0]} from decode (BR_BUS_WD)
//  fs_to_ds_valid     output  1    fs_to_ds_bus holds a valid bundle
//  fs_to_ds_bus       output  96   {inst[95:64], pc[63:0]} (FS_TO_DS_BUS_WD)
//  inst_sram_req      output  1    fetch request
//  inst_sram_addr     output  64   fetch address (= fetch PC)
//  inst_sram_addr_ok  input   1    request accepted this cycle (when req=1)
//  inst_sram_data_ok  input   1    rdata valid this cycle
//  inst_sram_rdata    input   32   fetched instruction
// BEHAVIOUR
//  - Reset (reset=0, async): pc<=RESET_PC, state<=S_REQ, cancel<=0, buffer<=0.
//    Outputs during reset: fs_to_ds_valid=0, inst_sram_req=0, fs_to_ds_bus=0.
//    First request on the first posedge after reset release.
//  - FSM:
//    S_REQ : req=1, addr=pc; addr_ok -> S_WAIT.
//    S_WAIT: req=0; data_ok -> capture {rdata,pc} in buffer, -> S_FULL.
//    S_FULL: fs_to_ds_valid=1; transfer (valid&&ds_allowin) -> pc<=pc+4, -> S_REQ.
//  - At most one outstanding request. data_ok is ignored in S_REQ and S_FULL.
//  - Minimum latency: addr_ok at T, data_ok at T+1, valid at T+2. Peak rate is 1 inst per 3 cycles.
//  - Stall: ds_allowin=0 in S_FULL -> bundle held bit-stable, no new request.
//    If addr_ok=0, req and addr stay stable.
//  - Redirect fires when br_taken && ds_allowin, i.e. the branch is leaving decode that cycle.
//    br_taken with ds_allowin=0 has no effect. On a redirect:
//      * fs_to_ds_valid is forced 0 that cycle; the wrong-path bundle is dropped.
//      * pc<=br_target (full 64b, no alignment check); the next state depends on the current state:
//        S_REQ, not accepted: stay S_REQ; addr=br_target from the next cycle.
//        S_REQ with addr_ok the same cycle: -> S_WAIT with cancel=1.
//        S_WAIT: cancel<=1; on data_ok drop the data, clear cancel, -> S_REQ.
//        S_WAIT with data_ok the same cycle: drop the data, -> S_REQ.
//        S_FULL: -> S_REQ.
//      * A second redirect while cancel=1 only updates pc; cancel stays 1.
//  - PC arithmetic is 64b modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
//  - Async reset in S_WAIT: the stale data_ok after release lands in S_REQ and is ignored.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[63:0] and perf_redirect_cnt[63:0].
//    perf_fetch_cnt: +1 per fs->ds transfer. perf_redirect_cnt: +1 per redirect.
//    Both reset to 0 and wrap.
//  IF_PERF_CNT_EN undefined: no counters, no such ports, behaviour otherwise identical.
// STRUCTURE
//  - mycpu.h: FS_TO_DS_BUS_WD(96), BR_BUS_WD(65), FS state encodings (S_REQ=2'd0, S_WAIT=2'd1, S_FULL=2'd2).
//  - Sub-module if_pc_gen: pc register plus next-pc mux (RESET_PC / pc+4 / br_target).
//  - FSM, cancel flag and bundle buffer stay in if_stage.
// TESTING
//  1 Release reset; SRAM with addr_ok=1 and 1-cycle data_ok, rdata=32'h0000_0013.
//    -> req addr 0x8000_0000; 2 cycles after accept, valid=1, bus={32'h13,64'h8000_0000}.
//  2 Hold ds_allowin=0 for 5 cycles in S_FULL.
//    -> valid=1 and bus unchanged throughout, req=0; on allowin=1, next req addr 0x8000_0004.
//  3 Redirect in S_WAIT: br_bus={1,64'h8000_0100}, ds_allowin=1.
//    -> the following data_ok is dropped (no valid); next req addr 0x8000_0100; next bundle pc 0x8000_0100.
//  4 br_taken=1 with ds_allowin=0 for 3 cycles -> no redirect, pc unchanged.
//    Then raise allowin -> redirect that cycle, valid=0.
//  5 addr_ok held 0 for 3 cycles -> req=1, addr stable; accept on cycle 4 -> S_WAIT.
//  6 Assert reset mid-S_WAIT, then a late data_ok after release.
//    -> valid=0 at once, data ignored, first req at RESET_PC.
//    With IF_PERF_CNT_EN: 10 transfers and 2 redirects -> counts 10 and 2.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared widths, fetch-state encodings and bus layouts for the IF stage.
package if_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 96;
  localparam int BR_BUS_WD       = 65;

  // Fetch FSM encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  // {inst, pc} bundle handed to decode
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fs_bundle_t;

  // {taken, target} redirect bus coming back from decode
  typedef struct packed {
    logic        taken;
    logic [63:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC register with next-PC selection: reset value, sequential +4, or
// redirect target. Redirect wins over sequential advance.
module if_pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [63:0] target_i,
  input  logic        advance_i,
  output logic [63:0] pc_o
);

  logic [63:0] pc_q, pc_d;

  // Next-PC mux; +4 wraps naturally modulo 2^64
  always_comb begin
    pc_d = pc_q;
    if (redirect_i)     pc_d = target_i;
    else if (advance_i) pc_d = pc_q + 64'd4;
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding request on the inst SRAM port,
// one-entry bundle buffer toward decode, redirects from decode's br_bus.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/redirect counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [63:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]                perf_fetch_cnt,
  output logic [63:0]                perf_redirect_cnt
`endif
);

  br_bus_t    br;
  fs_bundle_t buf_q, buf_d;
  logic [1:0] state_q, state_d;
  logic       cancel_q, cancel_d;
  logic [63:0] pc;
  logic       redirect, accept, xfer;

  assign br = br_bus;

  // A redirect only counts when the branch actually leaves decode
  assign redirect = br.taken && ds_allowin;

  // Request is gated by reset so nothing is issued while held in reset
  assign inst_sram_req  = (state_q == S_REQ) && reset;
  assign inst_sram_addr = pc;
  assign accept         = inst_sram_req && inst_sram_addr_ok;

  // Wrong-path bundle is suppressed in the cycle the redirect fires
  assign fs_to_ds_valid = (state_q == S_FULL) && !redirect;
  assign fs_to_ds_bus   = buf_q;
  assign xfer           = fs_to_ds_valid && ds_allowin;

  if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk        (clk),
    .rst_n      (reset),
    .redirect_i (redirect),
    .target_i   (br.target),
    .advance_i  (xfer),
    .pc_o       (pc)
  );

  // Fetch FSM, cancel tracking for in-flight wrong-path data, and buffer fill.
  // pc is frozen while waiting unless a redirect arrives (which also sets
  // cancel), so the captured pc always matches the returning data.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    buf_d    = buf_q;
    case (state_q)
      S_REQ: begin
        if (accept) begin
          state_d  = S_WAIT;
          cancel_d = redirect;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (cancel_q || redirect) begin
            state_d  = S_REQ;
            cancel_d = 1'b0;
          end else begin
            state_d = S_FULL;
            buf_d   = '{inst: inst_sram_rdata, pc: pc};
          end
        end else if (redirect) begin
          cancel_d = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect || xfer) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // State, cancel flag and bundle buffer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      cancel_q <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      buf_q    <= buf_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, redir_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (xfer)     fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (redirect) redir_cnt_q <= redir_cnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule
